// File: rtl/memory_writeback_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_writeback_if : MEM/WB stage inputs, control and writeback outputs    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface memory_writeback_if;
  logic        stall;
  logic        flush;
  logic        valid_in;
  logic        RegWrite_in;
  logic        FRegWrite_in;
  logic [1:0]  ResultSrc_in;
  logic [4:0]  rd_in;
  logic [31:0] muxpal_result_in;
  logic [31:0] ReadData_in;
  logic [31:0] PCPlus4_in;
  logic [31:0] ImmExt_in;

  logic        valid_wb;
  logic [4:0]  rd_wb;
  logic [31:0] Result_wb;
  logic        RegWrite_wb;
  logic        FRegWrite_wb;
  logic        conflict_err;
  logic [63:0] instret;

  modport master (
    output stall, flush, valid_in, RegWrite_in, FRegWrite_in, ResultSrc_in,
           rd_in, muxpal_result_in, ReadData_in, PCPlus4_in, ImmExt_in,
    input  valid_wb, rd_wb, Result_wb, RegWrite_wb, FRegWrite_wb,
           conflict_err, instret
  );

  modport slave (
    input  stall, flush, valid_in, RegWrite_in, FRegWrite_in, ResultSrc_in,
           rd_in, muxpal_result_in, ReadData_in, PCPlus4_in, ImmExt_in,
    output valid_wb, rd_wb, Result_wb, RegWrite_wb, FRegWrite_wb,
           conflict_err, instret
  );
endinterface
`default_nettype wire

// File: rtl/memory_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_writeback : MEM/WB pipeline register, result select, RF write steer |
// | Optional retired counter via macro MEMORY_WRITEBACK_INSTRET_EN             |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module memory_writeback (
  input  wire logic         clk,
  input  wire logic         reset,
  memory_writeback_if.slave bus
);

  localparam logic [1:0] C_SRC_ALU  = 2'b00;
  localparam logic [1:0] C_SRC_LOAD = 2'b01;
  localparam logic [1:0] C_SRC_PC4  = 2'b10;

  logic        valid_q,     valid_d;
  logic        regwrite_q,  regwrite_d;
  logic        fregwrite_q, fregwrite_d;
  logic [1:0]  src_q,       src_d;
  logic [4:0]  rd_q,        rd_d;
  logic [31:0] alu_q,       alu_d;
  logic [31:0] load_q,      load_d;
  logic [31:0] pc4_q,       pc4_d;
  logic [31:0] imm_q,       imm_d;
  logic        conflict_q,  conflict_d;

  always_comb begin
    valid_d     = valid_q;
    regwrite_d  = regwrite_q;
    fregwrite_d = fregwrite_q;
    src_d       = src_q;
    rd_d        = rd_q;
    alu_d       = alu_q;
    load_d      = load_q;
    pc4_d       = pc4_q;
    imm_d       = imm_q;
    if (bus.flush) begin
      // Bubble only kills the control bits; data fields are left as they were.
      valid_d     = 1'b0;
      regwrite_d  = 1'b0;
      fregwrite_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d     = bus.valid_in;
      regwrite_d  = bus.RegWrite_in;
      fregwrite_d = bus.FRegWrite_in;
      src_d       = bus.ResultSrc_in;
      rd_d        = bus.rd_in;
      alu_d       = bus.muxpal_result_in;
      load_d      = bus.ReadData_in;
      pc4_d       = bus.PCPlus4_in;
      imm_d       = bus.ImmExt_in;
    end
    conflict_d = conflict_q | (valid_q & regwrite_q & fregwrite_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      fregwrite_q <= 1'b0;
      src_q       <= 2'b00;
      rd_q        <= 5'd0;
      alu_q       <= 32'd0;
      load_q      <= 32'd0;
      pc4_q       <= 32'd0;
      imm_q       <= 32'd0;
      conflict_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      regwrite_q  <= regwrite_d;
      fregwrite_q <= fregwrite_d;
      src_q       <= src_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      load_q      <= load_d;
      pc4_q       <= pc4_d;
      imm_q       <= imm_d;
      conflict_q  <= conflict_d;
    end
  end

  always_comb begin
    case (src_q)
      C_SRC_ALU:  bus.Result_wb = alu_q;
      C_SRC_LOAD: bus.Result_wb = load_q;
      C_SRC_PC4:  bus.Result_wb = pc4_q;
      default:    bus.Result_wb = imm_q;
    endcase
  end

  // FP write takes precedence; x0 is never written on the integer side.
  assign bus.RegWrite_wb  = valid_q & regwrite_q & ~fregwrite_q & (rd_q != 5'd0);
  assign bus.FRegWrite_wb = valid_q & fregwrite_q;
  assign bus.valid_wb     = valid_q;
  assign bus.rd_wb        = rd_q;
  assign bus.conflict_err = conflict_q;

`ifdef MEMORY_WRITEBACK_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= 64'd0;
    end else if (!bus.stall && valid_q) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign bus.instret = instret_q;
`else
  assign bus.instret = 64'd0;
`endif

endmodule
`default_nettype wire
